ppi_bus_master: RTL and testbench

//  CPU-side initiator for the 8255 PPI bus: turns a single-word request handshake into a

---
 rtl/ppi_bus_master_if.sv | 33 +++
 rtl/ppi_bus_master.sv | 185 ++++++++++++++++++
 tb/tb_ppi_bus_master.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ppi_bus_master_if.sv
// ----------------------------------------------------------------------------
// Module : ppi_bus_master_if
// Request handshake plus 8255 control pins for the PPI bus master.
// Rev    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface ppi_bus_master_if;
   logic       req;
   logic       req_wr;
   logic [1:0] req_addr;
   logic [7:0] req_wdata;
   logic       ready;
   logic       done;
   logic [7:0] rdata;
   logic       ppi_reset;
   logic       cs;
   logic       rd;
   logic       wr;
   logic [1:0] a;

   modport master (
      input  req, req_wr, req_addr, req_wdata,
      output ready, done, rdata, ppi_reset, cs, rd, wr, a
   );

   modport slave (
      output req, req_wr, req_addr, req_wdata,
      input  ready, done, rdata, ppi_reset, cs, rd, wr, a
   );
endinterface

`default_nettype wire

// File: rtl/ppi_bus_master.sv
// ----------------------------------------------------------------------------
// Module : ppi_bus_master
// Turns one request word into a timed 8255 bus cycle; issues PPI RESET at boot.
// Rev    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ppi_bus_master #(
   parameter int RST_CYC   = 8,
   parameter int SETUP_CYC = 1,
   parameter int PULSE_CYC = 3,
   parameter int HOLD_CYC  = 1
) (
   input  wire               clk_i,
   input  wire               reset_n_i,
   ppi_bus_master_if.master  bus,
   inout  wire  [7:0]        d_io
);

   localparam int MAX_A   = (RST_CYC > SETUP_CYC) ? RST_CYC : SETUP_CYC;
   localparam int MAX_B   = (PULSE_CYC > HOLD_CYC) ? PULSE_CYC : HOLD_CYC;
   localparam int MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int CNT_W   = $clog2(MAX_CYC) + 1;

   localparam logic [CNT_W-1:0] RST_LAST   = CNT_W'(RST_CYC - 1);
   localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
   localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYC - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);

   typedef enum logic [2:0] {
      S_INIT   = 3'd0,
      S_IDLE   = 3'd1,
      S_SETUP  = 3'd2,
      S_STROBE = 3'd3,
      S_HOLD   = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             is_wr_q, is_wr_d;
   logic             ready_q, ready_d;
   logic             done_q, done_d;
   logic [7:0]       rdata_q, rdata_d;
   logic             ppi_reset_q, ppi_reset_d;
   logic             cs_n_q, cs_n_d;
   logic             rd_n_q, rd_n_d;
   logic             wr_n_q, wr_n_d;
   logic [1:0]       a_q, a_d;
   logic [7:0]       dout_q, dout_d;
   logic             doe_q, doe_d;

   // Every output is computed for the coming state so the pins change on the edge.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      is_wr_d     = is_wr_q;
      ready_d     = ready_q;
      done_d      = 1'b0;
      rdata_d     = rdata_q;
      ppi_reset_d = ppi_reset_q;
      cs_n_d      = cs_n_q;
      rd_n_d      = rd_n_q;
      wr_n_d      = wr_n_q;
      a_d         = a_q;
      dout_d      = dout_q;
      doe_d       = doe_q;

      case (state_q)
         S_INIT: begin
            if (cnt_q == RST_LAST) begin
               state_d     = S_IDLE;
               cnt_d       = '0;
               ppi_reset_d = 1'b0;
               ready_d     = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_IDLE: begin
            if (bus.req) begin
               state_d = S_SETUP;
               cnt_d   = '0;
               ready_d = 1'b0;
               is_wr_d = bus.req_wr;
               a_d     = bus.req_addr;
               dout_d  = bus.req_wdata;
               doe_d   = bus.req_wr;
               cs_n_d  = 1'b0;
            end
         end
         S_SETUP: begin
            if (cnt_q == SETUP_LAST) begin
               state_d = S_STROBE;
               cnt_d   = '0;
               rd_n_d  = is_wr_q;
               wr_n_d  = ~is_wr_q;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_STROBE: begin
            if (cnt_q == PULSE_LAST) begin
               state_d = S_HOLD;
               cnt_d   = '0;
               rd_n_d  = 1'b1;
               wr_n_d  = 1'b1;
               if (!is_wr_q) begin
                  rdata_d = d_io;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_HOLD: begin
            if (cnt_q == HOLD_LAST) begin
               state_d = S_IDLE;
               cnt_d   = '0;
               cs_n_d  = 1'b1;
               doe_d   = 1'b0;
               done_d  = 1'b1;
               ready_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d     = S_INIT;
            cnt_d       = '0;
            ready_d     = 1'b0;
            ppi_reset_d = 1'b1;
            cs_n_d      = 1'b1;
            rd_n_d      = 1'b1;
            wr_n_d      = 1'b1;
            doe_d       = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         state_q     <= S_INIT;
         cnt_q       <= '0;
         is_wr_q     <= 1'b0;
         ready_q     <= 1'b0;
         done_q      <= 1'b0;
         rdata_q     <= '0;
         ppi_reset_q <= 1'b1;
         cs_n_q      <= 1'b1;
         rd_n_q      <= 1'b1;
         wr_n_q      <= 1'b1;
         a_q         <= '0;
         dout_q      <= '0;
         doe_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         is_wr_q     <= is_wr_d;
         ready_q     <= ready_d;
         done_q      <= done_d;
         rdata_q     <= rdata_d;
         ppi_reset_q <= ppi_reset_d;
         cs_n_q      <= cs_n_d;
         rd_n_q      <= rd_n_d;
         wr_n_q      <= wr_n_d;
         a_q         <= a_d;
         dout_q      <= dout_d;
         doe_q       <= doe_d;
      end
   end

   assign bus.ready     = ready_q;
   assign bus.done      = done_q;
   assign bus.rdata     = rdata_q;
   assign bus.ppi_reset = ppi_reset_q;
   assign bus.cs        = cs_n_q;
   assign bus.rd        = rd_n_q;
   assign bus.wr        = wr_n_q;
   assign bus.a         = a_q;

   // Output enable only ever set for write transactions, so D is released while RD is low.
   assign d_io = doe_q ? dout_q : 8'bz;

endmodule

`default_nettype wire

// File: tb/tb_ppi_bus_master.sv
// ----------------------------------------------------------------------------
// Module : tb_ppi_bus_master
// Directed self-checking bench for ppi_bus_master (default and 2/1/3 timing).
// Rev    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_ppi_bus_master;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       tb_drv;
   logic [7:0] tb_dval;
   wire  [7:0] d_w;
   wire  [7:0] d_w2;

   ppi_bus_master_if u_if ();
   ppi_bus_master_if u_if2 ();

   // Bench plays the 8255: drives D only while the DUT strobes RD.
   assign d_w = (tb_drv && !u_if.rd) ? tb_dval : 8'bz;

   ppi_bus_master u_dut (
      .clk_i     (clk),
      .reset_n_i (rst_n),
      .bus       (u_if),
      .d_io      (d_w)
   );

   ppi_bus_master #(
      .RST_CYC   (8),
      .SETUP_CYC (2),
      .PULSE_CYC (1),
      .HOLD_CYC  (3)
   ) u_dut2 (
      .clk_i     (clk),
      .reset_n_i (rst_n),
      .bus       (u_if2),
      .d_io      (d_w2)
   );

   int n_chk  = 0;
   int n_fail = 0;

   logic [15:0] cs_low_m, rd_low_m, wr_low_m, done_m;
   logic [7:0]  d_log     [0:15];
   logic [7:0]  rdata_log [0:15];
   logic [1:0]  a_log     [0:15];

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Called at a negedge; releases reset (REQ held high to prove it is ignored in INIT).
   task automatic pwrup(input string tag);
      int   n;
      logic ok;
      n  = 0;
      ok = 1'b1;
      rst_n           = 1'b1;
      u_if.req        = 1'b1;
      u_if.req_wr     = 1'b1;
      u_if.req_addr   = 2'd3;
      u_if.req_wdata  = 8'h9B;
      while (u_if.ppi_reset && n < 20) begin
         if (!(u_if.cs && u_if.rd && u_if.wr) || u_if.ready || u_if.done) ok = 1'b0;
         n++;
         @(negedge clk);
      end
      u_if.req = 1'b0;
      check({tag, "_len"},   n, 8);
      check({tag, "_ready"}, u_if.ready, 1'b1);
      check({tag, "_pins"},  ok, 1'b1);
   endtask

   // Issues one request at the current negedge and logs cycles 1..ncyc after acceptance.
   task automatic run_txn(input logic w, input logic [1:0] ad, input logic [7:0] wd, input int ncyc);
      check("txn_ready_pre", u_if.ready, 1'b1);
      cs_low_m = '0; rd_low_m = '0; wr_low_m = '0; done_m = '0;
      u_if.req       = 1'b1;
      u_if.req_wr    = w;
      u_if.req_addr  = ad;
      u_if.req_wdata = wd;
      @(negedge clk);
      u_if.req = 1'b0;
      for (int c = 1; c <= ncyc; c++) begin
         cs_low_m[c]  = !u_if.cs;
         rd_low_m[c]  = !u_if.rd;
         wr_low_m[c]  = !u_if.wr;
         done_m[c]    = u_if.done;
         d_log[c]     = d_w;
         rdata_log[c] = u_if.rdata;
         a_log[c]     = u_if.a;
         if (c < ncyc) @(negedge clk);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int       ndone, csgap, nlow, ndn;
      int       dcyc [0:2];
      logic [1:0] a7, a13;
      logic       d_ok;

      rst_n   = 1'b0;
      tb_drv  = 1'b0;
      tb_dval = 8'h00;
      u_if.req  = 1'b0; u_if.req_wr  = 1'b0; u_if.req_addr  = 2'd0; u_if.req_wdata  = 8'h00;
      u_if2.req = 1'b0; u_if2.req_wr = 1'b0; u_if2.req_addr = 2'd0; u_if2.req_wdata = 8'h00;
      repeat (3) @(negedge clk);

      // Reset state
      check("rst_ready",     u_if.ready, 1'b0);
      check("rst_done",      u_if.done, 1'b0);
      check("rst_rdata",     u_if.rdata, 8'h00);
      check("rst_ppi_reset", u_if.ppi_reset, 1'b1);
      check("rst_cs_rd_wr",  {u_if.cs, u_if.rd, u_if.wr}, 3'b111);
      check("rst_a",         u_if.a, 2'd0);

      // Power-up: 8 cycles of PPI_RESET, READY rises as it falls
      pwrup("pwrup");

      // Control-word write
      run_txn(1'b1, 2'd3, 8'h80, 8);
      check("wr_cs_mask",   cs_low_m, 16'h003E);
      check("wr_wr_mask",   wr_low_m, 16'h001C);
      check("wr_rd_mask",   rd_low_m, 16'h0000);
      check("wr_done_mask", done_m,   16'h0040);
      d_ok = 1'b1;
      for (int c = 1; c <= 5; c++) if (d_log[c] !== 8'h80 || a_log[c] !== 2'd3) d_ok = 1'b0;
      check("wr_d_a_held", d_ok, 1'b1);
      check("wr_rdata_untouched", rdata_log[6], 8'h00);

      // Read port B
      tb_drv  = 1'b1;
      tb_dval = 8'h33;
      run_txn(1'b0, 2'd1, 8'hEE, 8);
      check("rd_cs_mask",     cs_low_m, 16'h003E);
      check("rd_rd_mask",     rd_low_m, 16'h001C);
      check("rd_wr_mask",     wr_low_m, 16'h0000);
      check("rd_done_mask",   done_m,   16'h0040);
      check("rd_d_bus",       d_log[3], 8'h33);
      check("rd_rdata_early", rdata_log[4], 8'h00);
      check("rd_rdata_done",  rdata_log[6], 8'h33);
      check("rd_a",           a_log[2], 2'd1);
      check("rd_a_after",     a_log[7], 2'd1);
      tb_drv = 1'b0;

      // Following write leaves RDATA alone
      run_txn(1'b1, 2'd0, 8'h5A, 8);
      check("rdata_hold_wr", rdata_log[6], 8'h33);
      check("rdata_hold_d",  d_log[3], 8'h5A);

      // Back-to-back: REQ held, fields advanced on each DONE cycle
      ndone = 0; csgap = 0; a7 = 2'd3; a13 = 2'd3;
      for (int i = 0; i < 3; i++) dcyc[i] = 0;
      u_if.req = 1'b1; u_if.req_wr = 1'b1; u_if.req_addr = 2'd0; u_if.req_wdata = 8'hFF;
      for (int c = 1; c <= 24 && ndone < 3; c++) begin
         @(negedge clk);
         if (u_if.done) begin
            dcyc[ndone] = c;
            ndone++;
            if (ndone == 3) u_if.req = 1'b0;
            else            u_if.req_addr = ndone[1:0];
         end else if (u_if.cs) begin
            csgap++;
         end
         if (c == 7)  a7  = u_if.a;
         if (c == 13) a13 = u_if.a;
      end
      check("b2b_ndone",  ndone, 3);
      check("b2b_done1",  dcyc[0], 6);
      check("b2b_done2",  dcyc[1], 12);
      check("b2b_done3",  dcyc[2], 18);
      check("b2b_no_gap", csgap, 0);
      check("b2b_a2",     a7, 2'd1);
      check("b2b_a3",     a13, 2'd2);
      @(negedge clk);
      check("b2b_stop_cs", u_if.cs, 1'b1);

      // Busy: REQ pulsed during STROBE is dropped
      u_if.req = 1'b1; u_if.req_wr = 1'b1; u_if.req_addr = 2'd2; u_if.req_wdata = 8'h44;
      nlow = 0; ndn = 0;
      for (int c = 1; c <= 14; c++) begin
         @(negedge clk);
         if (c == 1) u_if.req = 1'b0;
         if (c == 3) begin
            check("busy_in_strobe", u_if.wr, 1'b0);
            u_if.req = 1'b1; u_if.req_addr = 2'd0; u_if.req_wdata = 8'h11;
         end
         if (c == 4) u_if.req = 1'b0;
         if (!u_if.cs) nlow++;
         if (u_if.done) ndn++;
      end
      check("busy_one_done", ndn, 1);
      check("busy_cs_low",   nlow, 5);

      // Abort: reset during STROBE of a write
      u_if.req = 1'b1; u_if.req_wr = 1'b1; u_if.req_addr = 2'd2; u_if.req_wdata = 8'hAA;
      @(negedge clk);
      u_if.req = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("abort_pre_wr", u_if.wr, 1'b0);
      check("abort_pre_d",  d_w, 8'hAA);
      rst_n = 1'b0;
      @(negedge clk);
      check("abort_pins",      {u_if.cs, u_if.rd, u_if.wr}, 3'b111);
      check("abort_done",      u_if.done, 1'b0);
      check("abort_ppi_reset", u_if.ppi_reset, 1'b1);
      check("abort_ready",     u_if.ready, 1'b0);
      check("abort_rdata",     u_if.rdata, 8'h00);
      @(negedge clk);
      pwrup("reinit");

      // Timing sweep on the 2/1/3 instance: DONE in cycle 7
      check("sweep_ready", u_if2.ready, 1'b1);
      cs_low_m = '0; wr_low_m = '0; done_m = '0;
      u_if2.req = 1'b1; u_if2.req_wr = 1'b1; u_if2.req_addr = 2'd1; u_if2.req_wdata = 8'hC3;
      @(negedge clk);
      u_if2.req = 1'b0;
      d_ok = 1'b1;
      for (int c = 1; c <= 9; c++) begin
         cs_low_m[c] = !u_if2.cs;
         wr_low_m[c] = !u_if2.wr;
         done_m[c]   = u_if2.done;
         if (c <= 6 && (d_w2 !== 8'hC3 || u_if2.a !== 2'd1)) d_ok = 1'b0;
         if (c < 9) @(negedge clk);
      end
      check("sweep_done_mask", done_m,   16'h0080);
      check("sweep_cs_mask",   cs_low_m, 16'h007E);
      check("sweep_wr_mask",   wr_low_m, 16'h0008);
      check("sweep_d_a",       d_ok, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
